dram_ctrl: RTL and testbench

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// Single-bank DRAM controller with an open-row policy.
// Accepts one word request at a time and sequences PRECHARGE / ACTIVATE /
// READ / WRITE with programmable tRP, tRCD and tWR gaps. Every command is
// registered so it is visible during the cycle the FSM sits in its state.
module dram_ctrl #(
  parameter int T_RP  = 5,
  parameter int T_RCD = 5,
  parameter int T_WR  = 5
) (
  input  logic        dram_clk,
  input  logic        dram_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_PRE_W = 3'd2;
  localparam logic [2:0] S_ACT   = 3'd3;
  localparam logic [2:0] S_ACT_W = 3'd4;
  localparam logic [2:0] S_RW    = 3'd5;
  localparam logic [2:0] S_RD_W  = 3'd6;
  localparam logic [2:0] S_WR_W  = 3'd7;

  // A timing value of 1 means no wait state at all; otherwise the wait
  // state lasts T-1 cycles, i.e. the counter starts at T-2 and exits at 0.
  localparam logic       RP_WAIT  = (T_RP  > 1);
  localparam logic       RCD_WAIT = (T_RCD > 1);
  localparam logic       WR_WAIT  = (T_WR  > 1);
  localparam logic [2:0] RP_LOAD  = RP_WAIT  ? 3'(T_RP  - 2) : 3'd0;
  localparam logic [2:0] RCD_LOAD = RCD_WAIT ? 3'(T_RCD - 2) : 3'd0;
  localparam logic [2:0] WR_LOAD  = WR_WAIT  ? 3'(T_WR  - 2) : 3'd0;

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_next_s;
  logic        open_r;
  logic [10:0] open_row_r;
  logic        lat_write_r;
  logic [20:0] lat_addr_r;
  logic [3:0]  lat_wstrb_r;
  logic [31:0] lat_wdata_r;

  logic        accept_s;
  logic        hit_s;
  logic        cur_write_s;
  logic [20:0] cur_addr_s;
  logic [3:0]  cur_wstrb_s;
  logic [31:0] cur_wdata_s;
  logic        rasn_s;
  logic        casn_s;
  logic [3:0]  wen_s;
  logic [10:0] a_s;
  logic [31:0] d_s;
  logic        capture_s;

  assign accept_s  = req_valid && req_ready;
  assign hit_s     = open_r && (req_addr[20:10] == open_row_r);
  assign capture_s = (state_r == S_RD_W) && DRAM_valid;

  // Commands issued on the accept edge must use the live request; later
  // commands use the fields latched at acceptance.
  assign cur_write_s = (state_r == S_IDLE) ? req_write : lat_write_r;
  assign cur_addr_s  = (state_r == S_IDLE) ? req_addr  : lat_addr_r;
  assign cur_wstrb_s = (state_r == S_IDLE) ? req_wstrb : lat_wstrb_r;
  assign cur_wdata_s = (state_r == S_IDLE) ? req_wdata : lat_wdata_r;

  // Next-state logic of the command sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (hit_s)        state_next_s = S_RW;
          else if (!open_r) state_next_s = S_ACT;
          else              state_next_s = S_PRE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_PRE:   state_next_s = RP_WAIT  ? S_PRE_W : S_ACT;
      S_PRE_W: state_next_s = (cnt_r == 3'd0) ? S_ACT : S_PRE_W;
      S_ACT:   state_next_s = RCD_WAIT ? S_ACT_W : S_RW;
      S_ACT_W: state_next_s = (cnt_r == 3'd0) ? S_RW : S_ACT_W;
      S_RW: begin
        if (lat_write_r) state_next_s = WR_WAIT ? S_WR_W : S_IDLE;
        else             state_next_s = S_RD_W;
      end
      S_RD_W:  state_next_s = DRAM_valid ? S_IDLE : S_RD_W;
      S_WR_W:  state_next_s = (cnt_r == 3'd0) ? S_IDLE : S_WR_W;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Wait counter: loaded when a wait state is entered, counts down inside it.
  always_comb begin
    cnt_next_s = 3'd0;
    case (state_next_s)
      S_PRE_W: cnt_next_s = (state_r == S_PRE_W) ? (cnt_r - 3'd1) : RP_LOAD;
      S_ACT_W: cnt_next_s = (state_r == S_ACT_W) ? (cnt_r - 3'd1) : RCD_LOAD;
      S_WR_W:  cnt_next_s = (state_r == S_WR_W)  ? (cnt_r - 3'd1) : WR_LOAD;
      default: cnt_next_s = 3'd0;
    endcase
  end

  // Command bus for the state being entered; NOP holds A and D.
  always_comb begin
    rasn_s = 1'b1;
    casn_s = 1'b1;
    wen_s  = 4'hF;
    a_s    = DRAM_A;
    d_s    = DRAM_D;
    case (state_next_s)
      S_PRE: begin
        rasn_s = 1'b0;
        wen_s  = 4'h0;
        a_s    = open_row_r;
      end
      S_ACT: begin
        rasn_s = 1'b0;
        a_s    = cur_addr_s[20:10];
      end
      S_RW: begin
        casn_s = 1'b0;
        a_s    = {1'b0, cur_addr_s[9:0]};
        if (cur_write_s) begin
          wen_s = ~cur_wstrb_s;
          d_s   = cur_wdata_s;
        end else begin
          wen_s = 4'hF;
          d_s   = DRAM_D;
        end
      end
      default: begin
        rasn_s = 1'b1;
        casn_s = 1'b1;
        wen_s  = 4'hF;
        a_s    = DRAM_A;
        d_s    = DRAM_D;
      end
    endcase
  end

  // FSM state, wait counter and the IDLE-only ready flag.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 3'd0;
      req_ready <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      req_ready <= (state_next_s == S_IDLE);
    end
  end

  // Registered DRAM command/address/data pins.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      DRAM_CSn  <= 1'b1;
      DRAM_RASn <= 1'b1;
      DRAM_CASn <= 1'b1;
      DRAM_WEn  <= 4'hF;
      DRAM_A    <= 11'd0;
      DRAM_D    <= 32'd0;
    end else begin
      DRAM_CSn  <= 1'b0;
      DRAM_RASn <= rasn_s;
      DRAM_CASn <= casn_s;
      DRAM_WEn  <= wen_s;
      DRAM_A    <= a_s;
      DRAM_D    <= d_s;
    end
  end

  // Request latch and open-row bookkeeping.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      lat_write_r <= 1'b0;
      lat_addr_r  <= 21'd0;
      lat_wstrb_r <= 4'd0;
      lat_wdata_r <= 32'd0;
      open_r      <= 1'b0;
      open_row_r  <= 11'd0;
    end else begin
      if (accept_s) begin
        lat_write_r <= req_write;
        lat_addr_r  <= req_addr;
        lat_wstrb_r <= req_wstrb;
        lat_wdata_r <= req_wdata;
      end
      if (state_next_s == S_PRE) begin
        open_r <= 1'b0;
      end else if (state_next_s == S_ACT) begin
        open_r     <= 1'b1;
        open_row_r <= cur_addr_s[20:10];
      end
    end
  end

  // Read response: capture DRAM_Q while waiting, pulse rsp_valid once.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      rsp_valid <= capture_s;
      if (capture_s) rsp_data <= DRAM_Q;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with default timing (5/5/5). Inputs are
// driven and outputs sampled on the falling edge of dram_clk.
module tb_dram_ctrl;

  logic        dram_clk;
  logic        dram_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [20:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        DRAM_CSn;
  logic        DRAM_RASn;
  logic        DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q;
  logic        DRAM_valid;
  logic [17:0] bus;

  int vectors;
  int miscompares;

  dram_ctrl dut (
    .dram_clk(dram_clk), .dram_rst(dram_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );

  assign bus = {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A};

  initial dram_clk = 1'b0;
  always #5 dram_clk = ~dram_clk;

  function automatic logic [17:0] cmd(input logic ras, input logic cas,
                                      input logic [3:0] wen, input logic [10:0] a);
    return {1'b0, ras, cas, wen, a};
  endfunction

  task automatic step();
    @(negedge dram_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nops(input string tag, input int n, input logic [10:0] a);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, bus, cmd(1'b1, 1'b1, 4'hF, a));
      chk({tag, "_rdy"}, req_ready, 1'b0);
    end
  endtask

  task automatic req(input logic wr, input logic [20:0] addr,
                     input logic [3:0] strb, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = data;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dram_rst    = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 21'd0;
    req_wstrb   = 4'd0;
    req_wdata   = 32'd0;
    DRAM_Q      = 32'd0;
    DRAM_valid  = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_bus", bus, {1'b1, 1'b1, 1'b1, 4'hF, 11'h000});
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_d", DRAM_D, 32'd0);
    dram_rst = 1'b0;
    step();
    chk("rel_ready", req_ready, 1'b1);
    chk("rel_nop", bus, cmd(1'b1, 1'b1, 4'hF, 11'h000));

    // Cold read 000405
    req(1'b0, 21'h000405, 4'h0, 32'd0);
    step();
    req_valid = 1'b0;
    chk("cold_act", bus, cmd(1'b0, 1'b1, 4'hF, 11'h001));
    chk("cold_act_rdy", req_ready, 1'b0);
    nops("cold_trcd", 4, 11'h001);
    step();
    chk("cold_read", bus, cmd(1'b1, 1'b0, 4'hF, 11'h005));
    step();
    chk("cold_rdw", bus, cmd(1'b1, 1'b1, 4'hF, 11'h005));
    step();
    DRAM_valid = 1'b1;
    DRAM_Q     = 32'hDEADBEEF;
    chk("cold_wait_rsp", rsp_valid, 1'b0);
    step();
    DRAM_valid = 1'b0;
    DRAM_Q     = 32'h0;
    chk("cold_rsp_valid", rsp_valid, 1'b1);
    chk("cold_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("cold_ready", req_ready, 1'b1);

    // Row-hit write, req_valid held; fields change to a read mid-transaction
    req(1'b1, 21'h000406, 4'b0011, 32'h12345678);
    step();
    chk("rsp_pulse_once", rsp_valid, 1'b0);
    req(1'b0, 21'h000407, 4'b1111, 32'hFFFF0000);
    chk("hit_write", bus, cmd(1'b1, 1'b0, 4'b1100, 11'h006));
    chk("hit_write_d", DRAM_D, 32'h12345678);
    chk("hit_write_rdy", req_ready, 1'b0);
    nops("hit_twr", 4, 11'h006);
    chk("hit_d_hold", DRAM_D, 32'h12345678);
    step();
    chk("hit_ready_back", req_ready, 1'b1);
    chk("hit_idle_nop", bus, cmd(1'b1, 1'b1, 4'hF, 11'h006));
    step();
    req_valid = 1'b0;
    chk("held_read", bus, cmd(1'b1, 1'b0, 4'hF, 11'h007));
    chk("held_read_rdy", req_ready, 1'b0);
    step();
    DRAM_valid = 1'b1;
    DRAM_Q     = 32'hA5A55A5A;
    step();
    DRAM_valid = 1'b0;
    chk("held_rsp_valid", rsp_valid, 1'b1);
    chk("held_rsp_data", rsp_data, 32'hA5A55A5A);

    // Row miss 000C00, inputs scrambled after acceptance, stray DRAM_valid
    req(1'b0, 21'h000C00, 4'h0, 32'd0);
    step();
    req_valid = 1'b0;
    req_write = 1'b1;
    req_addr  = 21'h1FFFFF;
    chk("miss_pre", bus, cmd(1'b0, 1'b1, 4'h0, 11'h001));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("miss_trp", bus, cmd(1'b1, 1'b1, 4'hF, 11'h001));
      if (i == 2) chk("stray_valid_ignored", rsp_valid, 1'b0);
      DRAM_valid = (i == 1);
      DRAM_Q     = 32'h0BAD0BAD;
    end
    step();
    chk("miss_act", bus, cmd(1'b0, 1'b1, 4'hF, 11'h003));
    nops("miss_trcd", 4, 11'h003);
    step();
    chk("miss_read", bus, cmd(1'b1, 1'b0, 4'hF, 11'h000));
    step();
    DRAM_valid = 1'b1;
    DRAM_Q     = 32'h0BADF00D;
    step();
    DRAM_valid = 1'b0;
    chk("miss_rsp_valid", rsp_valid, 1'b1);
    chk("miss_rsp_data", rsp_data, 32'h0BADF00D);

    // Reset during RD_W, then a late DRAM_valid
    req(1'b0, 21'h000C08, 4'h0, 32'd0);
    step();
    req_valid = 1'b0;
    chk("mid_read", bus, cmd(1'b1, 1'b0, 4'hF, 11'h008));
    step();
    dram_rst = 1'b1;
    step();
    chk("mid_rst_bus", bus, {1'b1, 1'b1, 1'b1, 4'hF, 11'h000});
    chk("mid_rst_ready", req_ready, 1'b0);
    dram_rst = 1'b0;
    step();
    chk("mid_rel_ready", req_ready, 1'b1);
    chk("mid_rel_rsp", rsp_valid, 1'b0);
    DRAM_valid = 1'b1;
    DRAM_Q     = 32'h77777777;
    req(1'b0, 21'h000C10, 4'h0, 32'd0);
    step();
    req_valid  = 1'b0;
    DRAM_valid = 1'b0;
    chk("late_valid_no_rsp", rsp_valid, 1'b0);
    chk("post_rst_act", bus, cmd(1'b0, 1'b1, 4'hF, 11'h003));
    nops("post_rst_trcd", 4, 11'h003);
    step();
    chk("post_rst_read", bus, cmd(1'b1, 1'b0, 4'hF, 11'h010));
    step();
    DRAM_valid = 1'b1;
    DRAM_Q     = 32'hCAFEF00D;
    step();
    DRAM_valid = 1'b0;
    chk("post_rst_rsp", rsp_data, 32'hCAFEF00D);
    chk("post_rst_rsp_valid", rsp_valid, 1'b1);

    // Boundary address 1FFFFF (miss against row 003)
    req(1'b0, 21'h1FFFFF, 4'h0, 32'd0);
    step();
    req_valid = 1'b0;
    chk("bnd_pre", bus, cmd(1'b0, 1'b1, 4'h0, 11'h003));
    nops("bnd_trp", 4, 11'h003);
    step();
    chk("bnd_act", bus, cmd(1'b0, 1'b1, 4'hF, 11'h7FF));
    nops("bnd_trcd", 4, 11'h7FF);
    step();
    chk("bnd_read", bus, cmd(1'b1, 1'b0, 4'hF, 11'h3FF));
    step();
    DRAM_valid = 1'b1;
    DRAM_Q     = 32'h13579BDF;
    step();
    DRAM_valid = 1'b0;
    chk("bnd_rsp", rsp_data, 32'h13579BDF);

    // Zero-strobe write hit on row 7FF keeps full write timing
    req(1'b1, 21'h1FFFFE, 4'h0, 32'h00000000);
    step();
    req_valid = 1'b0;
    chk("zstrb_write", bus, cmd(1'b1, 1'b0, 4'hF, 11'h3FE));
    chk("zstrb_d", DRAM_D, 32'h00000000);
    nops("zstrb_twr", 4, 11'h3FE);
    step();
    chk("zstrb_ready", req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
